// File: rtl/multi_ctrl_fsm_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcodes,
// datapath mux encodings and the control-output bundle.
// Watchdog build option: MULTI_CTRL_WDOG_EN.
package multi_ctrl_fsm_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_FAULT    = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic       ireg_enab;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_enab;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_srcA;
    logic [1:0] alu_srcB;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Execute-phase entry state for an opcode; ST_FETCH marks an unsupported opcode.
  function automatic state_t decode_op(input logic [OPC_W-1:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = ST_MEMADR;
      OP_RTYPE:     nxt = ST_EXECUTE;
      OP_BEQ:       nxt = ST_BRANCH;
      OP_ADDI:      nxt = ST_ADDIEXEC;
      OP_J:         nxt = ST_JUMP;
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multi_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller side.
// Watchdog build option: MULTI_CTRL_WDOG_EN.
interface multi_ctrl_fsm_if
  import multi_ctrl_fsm_pkg::*;
#(
  parameter int unsigned OP_W = 6
);

  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               mem_req;
  logic               i_or_d;
  logic               ireg_enab;
  logic [1:0]         pc_src;
  logic               pc_write;
  logic               branch;
  logic               mem_to_reg;
  logic               mem_enab;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_srcA;
  logic [1:0]         alu_srcB;
  logic [1:0]         alu_op;
  logic [STATE_W-1:0] state;
  logic               instr_done;
  logic               illegal_op;
  logic               fault;

  modport master (
    input  op, mem_ready,
    output mem_req, i_or_d, ireg_enab, pc_src, pc_write, branch, mem_to_reg,
           mem_enab, reg_dst, reg_write, alu_srcA, alu_srcB, alu_op, state,
           instr_done, illegal_op, fault
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, i_or_d, ireg_enab, pc_src, pc_write, branch, mem_to_reg,
           mem_enab, reg_dst, reg_write, alu_srcA, alu_srcB, alu_op, state,
           instr_done, illegal_op, fault
  );

endinterface

// File: rtl/multi_ctrl_fsm_mem_wdog.sv
// Memory wait-state watchdog: counts consecutive un-acked request cycles
// and flags when the tolerated limit is reached with the access still pending.
// Only present when MULTI_CTRL_WDOG_EN is defined.
`ifdef MULTI_CTRL_WDOG_EN
module multi_ctrl_fsm_mem_wdog #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic trip_c
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             at_limit_c;

  assign at_limit_c = (cnt_q == CNT_W'(MEM_WAIT_MAX));
  assign trip_c     = mem_req && !mem_ready && at_limit_c;

  // Wait counter; held at zero outside requests so each access starts fresh.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!mem_req || mem_ready) begin
      cnt_q <= '0;
    end else if (!at_limit_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/multi_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS-subset CPU (LW, SW, R, BEQ, ADDI, J)
// with a request/ready memory handshake. Outputs decode the state register
// and mem_ready combinationally. Define MULTI_CTRL_WDOG_EN to add the
// memory watchdog and the sticky FAULT state.
module multi_ctrl_fsm
  import multi_ctrl_fsm_pkg::*;
#(
  parameter int unsigned OP_W = 6
`ifdef MULTI_CTRL_WDOG_EN
  , parameter int unsigned MEM_WAIT_MAX = 16
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  multi_ctrl_fsm_if.master bus
);

  state_t            state_q;
  state_t            state_d;
  ctrl_t             ctrl_c;
  logic [OP_W-1:0]   op_c;
  logic [OPC_W-1:0]  opc_c;
  logic              ready_c;

  assign op_c    = bus.op;
  assign opc_c   = OPC_W'(op_c);
  assign ready_c = bus.mem_ready;

`ifdef MULTI_CTRL_WDOG_EN
  logic req_c;
  logic trip_c;

  assign req_c = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                 (state_q == ST_MEMWR);

  multi_ctrl_fsm_mem_wdog #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (req_c),
    .mem_ready (ready_c),
    .trip_c    (trip_c)
  );
`endif

  // State register, synchronous active-low reset back to FETCH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; everything defaults low, reset forces all low.
  always_comb begin
    ctrl_c  = '0;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_srcB  = ALUB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_src    = PCSRC_ALU;
        ctrl_c.ireg_enab = ready_c;
        ctrl_c.pc_write  = ready_c;
        if (ready_c) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl_c.alu_srcB   = ALUB_IMM_SL2;
        state_d           = decode_op(opc_c);
        ctrl_c.illegal_op = (decode_op(opc_c) == ST_FETCH);
      end
      ST_MEMADR: begin
        ctrl_c.alu_srcA = 1'b1;
        ctrl_c.alu_srcB = ALUB_IMM;
        state_d         = (opc_c == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.i_or_d  = 1'b1;
        if (ready_c) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl_c.mem_req    = 1'b1;
        ctrl_c.i_or_d     = 1'b1;
        ctrl_c.mem_enab   = 1'b1;
        ctrl_c.instr_done = ready_c;
        if (ready_c) state_d = ST_FETCH;
      end
      ST_EXECUTE: begin
        ctrl_c.alu_srcA = 1'b1;
        ctrl_c.alu_srcB = ALUB_B;
        ctrl_c.alu_op   = ALUOP_FUNCT;
        state_d         = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl_c.alu_srcA   = 1'b1;
        ctrl_c.alu_op     = ALUOP_SUB;
        ctrl_c.pc_src     = PCSRC_ALUOUT;
        ctrl_c.branch     = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_ADDIEXEC: begin
        ctrl_c.alu_srcA = 1'b1;
        ctrl_c.alu_srcB = ALUB_IMM;
        state_d         = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl_c.pc_src     = PCSRC_JUMP;
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
`ifdef MULTI_CTRL_WDOG_EN
    if (state_q == ST_FAULT) state_d = ST_FAULT;
    if (trip_c) state_d = ST_FAULT;
`endif
    if (!reset_n) ctrl_c = '0;
  end

  assign bus.mem_req    = ctrl_c.mem_req;
  assign bus.i_or_d     = ctrl_c.i_or_d;
  assign bus.ireg_enab  = ctrl_c.ireg_enab;
  assign bus.pc_src     = ctrl_c.pc_src;
  assign bus.pc_write   = ctrl_c.pc_write;
  assign bus.branch     = ctrl_c.branch;
  assign bus.mem_to_reg = ctrl_c.mem_to_reg;
  assign bus.mem_enab   = ctrl_c.mem_enab;
  assign bus.reg_dst    = ctrl_c.reg_dst;
  assign bus.reg_write  = ctrl_c.reg_write;
  assign bus.alu_srcA   = ctrl_c.alu_srcA;
  assign bus.alu_srcB   = ctrl_c.alu_srcB;
  assign bus.alu_op     = ctrl_c.alu_op;
  assign bus.instr_done = ctrl_c.instr_done;
  assign bus.illegal_op = ctrl_c.illegal_op;
  assign bus.state      = STATE_W'(state_q);

`ifdef MULTI_CTRL_WDOG_EN
  assign bus.fault = reset_n && (state_q == ST_FAULT);
`else
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Bench for multi_ctrl_fsm: directed vectors, hand sequences for reset and
// wait-state corners, and random instruction streams against a reference
// model. Watchdog checks are built when MULTI_CTRL_WDOG_EN is defined.
module tb_multi_ctrl_fsm;
  import multi_ctrl_fsm_pkg::*;

  localparam int unsigned WAIT_MAX = 4;

  logic clk;
  logic reset_n;

  multi_ctrl_fsm_if #(.OP_W(6)) bus ();

`ifdef MULTI_CTRL_WDOG_EN
  multi_ctrl_fsm #(.OP_W(6), .MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
`else
  multi_ctrl_fsm #(.OP_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t get_ctrl();
    ctrl_t c;
    c            = '0;
    c.mem_req    = bus.mem_req;
    c.i_or_d     = bus.i_or_d;
    c.ireg_enab  = bus.ireg_enab;
    c.pc_src     = bus.pc_src;
    c.pc_write   = bus.pc_write;
    c.branch     = bus.branch;
    c.mem_to_reg = bus.mem_to_reg;
    c.mem_enab   = bus.mem_enab;
    c.reg_dst    = bus.reg_dst;
    c.reg_write  = bus.reg_write;
    c.alu_srcA   = bus.alu_srcA;
    c.alu_srcB   = bus.alu_srcB;
    c.alu_op     = bus.alu_op;
    c.instr_done = bus.instr_done;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  // Reference: control values the datasheet table lists for each phase.
  function automatic ctrl_t spec_ctrl(input state_t s, input logic rdy, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH:    begin c.mem_req = 1; c.alu_srcB = 2'b01; c.ireg_enab = rdy; c.pc_write = rdy; end
      ST_DECODE:   begin
        c.alu_srcB   = 2'b11;
        c.illegal_op = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      ST_MEMADR:   begin c.alu_srcA = 1; c.alu_srcB = 2'b10; end
      ST_MEMRD:    begin c.mem_req = 1; c.i_or_d = 1; end
      ST_MEMWB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      ST_MEMWR:    begin c.mem_req = 1; c.i_or_d = 1; c.mem_enab = 1; c.instr_done = rdy; end
      ST_EXECUTE:  begin c.alu_srcA = 1; c.alu_op = 2'b10; end
      ST_ALUWB:    begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      ST_BRANCH:   begin c.alu_srcA = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1; c.instr_done = 1; end
      ST_ADDIEXEC: begin c.alu_srcA = 1; c.alu_srcB = 2'b10; end
      ST_ADDIWB:   begin c.reg_write = 1; c.instr_done = 1; end
      ST_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      default:     ;
    endcase
    return c;
  endfunction

  typedef struct {
    state_t st;
    logic   rdy;
  } step_t;

  step_t q[$];

  function automatic void push_wait(input state_t s, input int w);
    for (int i = 0; i < w; i++) q.push_back('{st: s, rdy: 1'b0});
    q.push_back('{st: s, rdy: 1'b1});
  endfunction

  function automatic void push_one(input state_t s);
    q.push_back('{st: s, rdy: 1'($urandom_range(0, 1))});
  endfunction

  // Expected phase list per instruction class, then cycle-by-cycle compare.
  task automatic run_model(input logic [5:0] op, input int wf, input int wm);
    q.delete();
    push_wait(ST_FETCH, wf);
    push_one(ST_DECODE);
    case (op)
      6'b100011: begin push_one(ST_MEMADR); push_wait(ST_MEMRD, wm); push_one(ST_MEMWB); end
      6'b101011: begin push_one(ST_MEMADR); push_wait(ST_MEMWR, wm); end
      6'b000000: begin push_one(ST_EXECUTE); push_one(ST_ALUWB); end
      6'b000100: push_one(ST_BRANCH);
      6'b001000: begin push_one(ST_ADDIEXEC); push_one(ST_ADDIWB); end
      6'b000010: push_one(ST_JUMP);
      default:   ;
    endcase
    foreach (q[i]) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.op        = (q[i].st == ST_FETCH) ? 6'($urandom) : op;
      bus.mem_ready = q[i].rdy;
      #1;
      check($sformatf("rnd_state op=%b i=%0d", op, i), 32'(bus.state), 32'(q[i].st));
      check($sformatf("rnd_ctrl op=%b i=%0d", op, i), 32'(get_ctrl()),
            32'(spec_ctrl(q[i].st, q[i].rdy, op)));
      check("rnd_fault", 32'(bus.fault), 32'd0);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int wf;
    int wm;
    int cycles;
    int dones;
    int rw;
    int me;
    int pw;
    int ill;
  } vec_t;

  vec_t tbl[10];

  // Drive one instruction reacting to mem_req, tally pulses until it retires.
  task automatic run_table(input int idx);
    vec_t v;
    int wf, wm, cyc, dones, rw, me, pw, ill;
    bit fin;
    v = tbl[idx];
    wf = v.wf; wm = v.wm;
    cyc = 0; dones = 0; rw = 0; me = 0; pw = 0; ill = 0; fin = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      reset_n = 1'b1;
      bus.op  = v.op;
      if (bus.mem_req) begin
        if (!bus.i_or_d) begin
          bus.mem_ready = (wf == 0);
          if (wf > 0) wf--;
        end else begin
          bus.mem_ready = (wm == 0);
          if (wm > 0) wm--;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (k == 0) check($sformatf("tbl%0d_start", idx), 32'(bus.state), 32'(ST_FETCH));
      cyc++;
      dones += int'(bus.instr_done);
      rw    += int'(bus.reg_write);
      me    += int'(bus.mem_enab);
      pw    += int'(bus.pc_write);
      ill   += int'(bus.illegal_op);
      if (bus.instr_done || bus.illegal_op) fin = 1;
    end
    check($sformatf("tbl%0d_retired", idx), 32'(fin), 32'd1);
    check($sformatf("tbl%0d_cycles", idx), 32'(cyc), 32'(v.cycles));
    check($sformatf("tbl%0d_dones", idx), 32'(dones), 32'(v.dones));
    check($sformatf("tbl%0d_regwrite", idx), 32'(rw), 32'(v.rw));
    check($sformatf("tbl%0d_memenab", idx), 32'(me), 32'(v.me));
    check($sformatf("tbl%0d_pcwrite", idx), 32'(pw), 32'(v.pw));
    check($sformatf("tbl%0d_illegal", idx), 32'(ill), 32'(v.ill));
  endtask

  // Hold reset for n cycles; outputs must be quiet and state FETCH.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n       = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.op        = 6'($urandom);
      #1;
      check("rst_state", 32'(bus.state), 32'(ST_FETCH));
      check("rst_ctrl", 32'(get_ctrl()), 32'd0);
      check("rst_fault", 32'(bus.fault), 32'd0);
    end
  endtask

  state_t lw_seq[5] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};

  initial begin
    int dones;
    reset_n       = 1'b0;
    bus.op        = 6'b0;
    bus.mem_ready = 1'b0;

    tbl[0] = '{6'b100011, 0, 0, 5, 1, 1, 0, 1, 0};
    tbl[1] = '{6'b101011, 0, 3, 7, 1, 0, 4, 1, 0};
    tbl[2] = '{6'b000000, 0, 0, 4, 1, 1, 0, 1, 0};
    tbl[3] = '{6'b001000, 0, 0, 4, 1, 1, 0, 1, 0};
    tbl[4] = '{6'b000100, 0, 0, 3, 1, 0, 0, 1, 0};
    tbl[5] = '{6'b000010, 0, 0, 3, 1, 0, 0, 2, 0};
    tbl[6] = '{6'b100011, 2, 1, 8, 1, 1, 0, 1, 0};
    tbl[7] = '{6'b111111, 0, 0, 2, 0, 0, 0, 1, 1};
    tbl[8] = '{6'b101011, 1, 0, 5, 1, 0, 1, 1, 0};
    tbl[9] = '{6'b000100, 3, 0, 6, 1, 0, 0, 1, 0};

    do_reset(3);

    // LW with zero-wait memory straight out of reset.
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.op        = 6'b100011;
      bus.mem_ready = 1'b1;
      #1;
      check($sformatf("lw_state%0d", i), 32'(bus.state), 32'(lw_seq[i]));
      dones += int'(bus.instr_done);
      if (i == 4) begin
        check("lw_regwrite", 32'(bus.reg_write), 32'd1);
        check("lw_memtoreg", 32'(bus.mem_to_reg), 32'd1);
      end
    end
    check("lw_done_count", 32'(dones), 32'd1);

    for (int i = 0; i < 10; i++) run_table(i);

    // Reset asserted while an R-type sits in ALUWB.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.op        = 6'b000000;
      bus.mem_ready = 1'b1;
      #1;
    end
    check("aluwb_state", 32'(bus.state), 32'(ST_ALUWB));
    check("aluwb_regwrite_pre", 32'(bus.reg_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("aluwb_regwrite_rst", 32'(bus.reg_write), 32'd0);
    check("aluwb_ctrl_rst", 32'(get_ctrl()), 32'd0);
    do_reset(1);

`ifdef MULTI_CTRL_WDOG_EN
    // Stuck fetch: WAIT_MAX tolerated waits, then FAULT on the next miss.
    for (int c = 0; c <= int'(WAIT_MAX); c++) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.op        = 6'($urandom);
      bus.mem_ready = 1'b0;
      #1;
      check($sformatf("wd_fetch%0d", c), 32'(bus.state), 32'(ST_FETCH));
      check($sformatf("wd_nofault%0d", c), 32'(bus.fault), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_ready = (c == 0) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("wd_fault_state%0d", c), 32'(bus.state), 32'(ST_FAULT));
      check($sformatf("wd_fault%0d", c), 32'(bus.fault), 32'd1);
      check($sformatf("wd_fault_ctrl%0d", c), 32'(get_ctrl()), 32'd0);
    end
    do_reset(1);

    // Ready arriving exactly at the limit completes the fetch.
    for (int c = 0; c < int'(WAIT_MAX); c++) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("wd_limit_ireg", 32'(bus.ireg_enab), 32'd1);
    @(negedge clk);
    bus.op        = 6'b000010;
    bus.mem_ready = 1'b0;
    #1;
    check("wd_limit_decode", 32'(bus.state), 32'(ST_DECODE));
    check("wd_limit_nofault", 32'(bus.fault), 32'd0);
    do_reset(1);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       op = 6'b100011;
        1:       op = 6'b101011;
        2:       op = 6'b000000;
        3:       op = 6'b000100;
        4:       op = 6'b001000;
        5:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      run_model(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_ctrl_fsm.md
# multi_ctrl_fsm

Main control state machine for the multicycle MIPS-subset CPU, sitting between the instruction register opcode field and the datapath mux/enable inputs. It sequences the full FETCH→DECODE→execute→writeback flow for LW, SW, R-type, BEQ, ADDI and J. It adds a memory request/ready handshake so fetch and data accesses tolerate variable wait states. An optional watchdog converts a stuck memory access into a sticky fault.

## Interface
- MEM_WAIT_MAX, 16, max consecutive wait cycles tolerated per access (watchdog build only; ≥1)
- OP_W, 6, opcode width
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- op  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access requested (FETCH, MEMRD, MEMWR)
- i_or_d  out  1  address mux: 0 = PC, 1 = ALUOut
- ireg_enab  out  1  instruction register load
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_write, branch  out  1 each  unconditional PC write / BEQ-qualified PC write
- mem_to_reg, mem_enab  out  1 each  writeback source / memory write enable
- reg_dst, reg_write  out  1 each  dest select (1 = rd) / register file write
- alu_srcA  out  1  0 = PC, 1 = A
- alu_srcB, alu_op  out  2 each  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2 / 00 add, 01 sub, 10 funct
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode
- fault  out  1  watchdog fault (sticky)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, FAULT.
- FETCH: mem_req=1, i_or_d=0, alu_srcA=0, alu_srcB=01, alu_op=00, pc_src=00; ireg_enab=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_srcA=0, alu_srcB=11, alu_op=00. Next: LW/SW(100011/101011)→MEMADR, R(000000)→EXECUTE, BEQ(000100)→BRANCH, ADDI(001000)→ADDIEXEC, J(000010)→JUMP, other→FETCH with illegal_op=1.
- MEMADR: alu_srcA=1, alu_srcB=10, alu_op=00; LW→MEMRD, SW→MEMWR.
- MEMRD: mem_req=1, i_or_d=1; hold until mem_ready→MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 →FETCH.
- MEMWR: mem_req=1, i_or_d=1, mem_enab=1; hold until mem_ready; instr_done=mem_ready; then FETCH.
- EXECUTE: alu_srcA=1, alu_srcB=00, alu_op=10 →ALUWB; ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 →FETCH.
- BRANCH: alu_srcA=1, alu_srcB=00, alu_op=01, pc_src=01, branch=1, instr_done=1 →FETCH.
- ADDIEXEC: alu_srcA=1, alu_srcB=10, alu_op=00 →ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 →FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 →FETCH.
- Every signal not listed for a state is 0 (never x) in that state.
- op is sampled only in DECODE and MEMADR; ireg holds it stable.

## Timing
- Outputs are combinational from state register and mem_ready; one transition per clk edge.
- Zero-wait memory: LW 5 cycles, SW 4, R 4, ADDI 4, BEQ 3, J 3. Each wait cycle adds one.
- mem_req asserted continuously until the cycle mem_ready=1; mem_ready outside a mem_req state is ignored.
- While reset_n=0: all enables, mem_req and pulses forced 0, muxes 0, fault 0; state loads FETCH at the edge. Reset mid-instruction abandons it, no partial write issued after the edge.

## Configuration
- MULTI_CTRL_WDOG_EN defined: wait counter (width $clog2(MEM_WAIT_MAX+1)) clears on entering any mem_req state and on mem_ready, increments each mem_req && !mem_ready cycle; when it equals MEM_WAIT_MAX with mem_ready still 0, next state FAULT. FAULT: all outputs 0 except fault=1; exits only via reset. mem_ready in the same cycle the count hits the limit completes normally.
- Undefined: no counter, no FAULT state; waits indefinitely; fault tied 0.

## Structure
- lib_state package: state enum (4-bit), opcode constants, alu_srcB/alu_op/pc_src encodings as named constants.
- Sub-module mem_wdog (counter + limit compare), instantiated only under MULTI_CTRL_WDOG_EN.

## Test plan
- Reset held 3 cycles, release, op=100011, mem_ready=1 always → states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1, mem_to_reg=1 in cycle 5; instr_done single pulse.
- SW with mem_ready low 3 cycles in MEMWR → mem_enab=1 and mem_req=1 for 4 cycles, instr_done only on 4th.
- op=000100 → BRANCH: branch=1, pc_src=01, alu_op=01, pc_write=0; op=000010 → JUMP: pc_write=1, pc_src=10.
- op=111111 → illegal_op pulse in DECODE, next state FETCH, no reg_write/mem_enab asserted.
- Watchdog build, MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH → FAULT after 4 wait cycles, fault=1 held, all enables 0 until reset_n=0.
- reset_n=0 during ALUWB → reg_write 0 in that cycle, state FETCH next cycle.
